uart_reply_tx: RTL and testbench

UART reply transmitter for the PSRAM-over-UART path. It accepts completed PSRAM transactions from the controller (read data or write acknowledge) through a small request FIFO. Each transaction is serialized as a framed, checksummed byte packet on `uart_tx` at 8N1, using the same bit timing and byte order as the command receiver. It is the return channel that pairs with the command-parsing receiver.

---
 rtl/uart_reply_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_reply_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reply_tx.sv
// UART reply transmitter: queues completed PSRAM transactions and sends
// each one as a framed, XOR-checksummed 8N1 byte packet on uart_tx.
module uart_reply_tx #(
   parameter int DELAY_FRAMES = 234,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        req_valid,
   input  logic        req_type,
   input  logic [23:0] req_addr,
   input  logic [15:0] req_data,
   output logic        req_ready,
   output logic        req_drop,
   output logic        busy,
   output logic        uart_tx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
   localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_MAX = CW'(DELAY_FRAMES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [40:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q;
   logic          push, pop;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [2:0]    byte_q, byte_d;
   logic [7:0]    chk_q, chk_d;
   logic          type_q, type_d;
   logic [23:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          tx_q, tx_d;
   logic          drop_q;

   logic [7:0]    cur_byte;
   logic          last_byte;
   logic          baud_end;

   assign req_ready = (cnt_q != FULL);
   assign push      = req_valid & req_ready;
   assign busy      = (state_q != S_IDLE) | (cnt_q != '0);
   assign req_drop  = drop_q;
   assign uart_tx   = tx_q;
   assign baud_end  = (baud_q == BAUD_MAX);
   assign last_byte = (byte_q == (type_q ? 3'd6 : 3'd4));

   always_ff @(posedge sys_clk) begin
      if (push) mem_q[wr_ptr_q] <= {req_type, req_addr, req_data};
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         drop_q   <= 1'b0;
      end else begin
         drop_q <= req_valid & ~req_ready;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Byte 4 doubles as the checksum slot for write acknowledges.
   always_comb begin
      unique case (byte_q)
         3'd0:    cur_byte = type_q ? 8'h44 : 8'h41;
         3'd1:    cur_byte = addr_q[7:0];
         3'd2:    cur_byte = addr_q[15:8];
         3'd3:    cur_byte = addr_q[23:16];
         3'd4:    cur_byte = type_q ? data_q[7:0] : chk_q;
         3'd5:    cur_byte = data_q[15:8];
         default: cur_byte = chk_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      chk_d   = chk_q;
      type_d  = type_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cnt_q != '0) begin
               pop = 1'b1;
               {type_d, addr_d, data_d} = mem_q[rd_ptr_q];
               byte_d  = '0;
               bit_d   = '0;
               baud_d  = '0;
               chk_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (last_byte) begin
                  state_d = S_IDLE;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  chk_d   = chk_q ^ cur_byte;
                  state_d = S_START;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
      endcase
   end

   // Line level is registered, so it trails the state by one cycle.
   always_comb begin
      unique case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = cur_byte[bit_q];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         chk_q   <= '0;
         type_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         chk_q   <= chk_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_reply_tx.sv
// Directed bench for uart_reply_tx: scoreboard of expected frame bytes,
// checked by a cycle-accurate UART receiver watching uart_tx.
module tb_uart_reply_tx;

   localparam int DF = 8;
   localparam int FD = 4;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_type  = 1'b0;
   logic [23:0] req_addr  = '0;
   logic [15:0] req_data  = '0;
   logic        req_ready, req_drop, busy, uart_tx;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   logic [7:0] exp_q[$];
   int         flen_q[$];
   int         gap_q[$];

   uart_reply_tx #(.DELAY_FRAMES(DF), .FIFO_DEPTH(FD)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .req_valid (req_valid),
      .req_type  (req_type),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .req_drop  (req_drop),
      .busy      (busy),
      .uart_tx   (uart_tx)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_frame(input logic t, input logic [23:0] a,
                               input logic [15:0] d);
      logic [7:0] f[$];
      logic [7:0] x;
      x = 8'h00;
      f.push_back(t ? 8'h44 : 8'h41);
      f.push_back(a[7:0]);
      f.push_back(a[15:8]);
      f.push_back(a[23:16]);
      if (t) begin
         f.push_back(d[7:0]);
         f.push_back(d[15:8]);
      end
      foreach (f[i]) begin
         exp_q.push_back(f[i]);
         x = x ^ f[i];
      end
      exp_q.push_back(x);
      flen_q.push_back(f.size() + 1);
   endtask

   task automatic push(input logic t, input logic [23:0] a,
                       input logic [15:0] d, output int k);
      @(posedge sys_clk); #1;
      req_valid = 1'b1;
      req_type  = t;
      req_addr  = a;
      req_data  = d;
      expect_frame(t, a, d);
      @(posedge sys_clk); #1;
      k = cyc;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("drain_in_time", n < 20000, 1);
   endtask

   // Receiver model: tracks frame/byte slots on a grid of DF cycles.
   int         bstart, fstart, bytes_left, pos;
   int         stop_rise = -1000;
   bit         in_byte   = 1'b0;
   logic       prev_tx   = 1'b1;
   logic [7:0] sh;

   initial forever begin
      @(negedge sys_clk);
      if (!mon_en || !sys_rst_n) begin
         in_byte    = 1'b0;
         bytes_left = 0;
      end else begin
         if (uart_tx !== prev_tx && (in_byte || bytes_left > 0))
            chk("bit_grid", (cyc - fstart) % DF, 0);
         if (!in_byte && uart_tx === 1'b0) begin
            if (bytes_left == 0) begin
               chk("frame_expected", flen_q.size() != 0, 1);
               bytes_left = (flen_q.size() != 0) ? flen_q.pop_front() : 1;
               gap_q.push_back(cyc - stop_rise);
               fstart = cyc;
            end
            chk("byte_slot", (cyc - fstart) % (10 * DF), 0);
            in_byte = 1'b1;
            bstart  = cyc;
         end else if (in_byte) begin
            pos = cyc - bstart;
            if (pos == 3) chk("start_bit", uart_tx, 0);
            if (pos > DF && pos < 9 * DF && pos % DF == 3)
               sh[pos / DF - 1] = uart_tx;
            if (pos == 9 * DF + 3) begin
               chk("stop_bit", uart_tx, 1);
               chk("byte_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) chk("byte", sh, exp_q.pop_front());
               stop_rise = bstart + 9 * DF;
               in_byte   = 1'b0;
               bytes_left--;
            end
         end
      end
      prev_tx = uart_tx;
   end

   initial begin
      int k, k2, n;
      bit saw_low;
      logic exp_rdy[6];
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_tx", uart_tx, 1);
      chk("rst_ready", req_ready, 1);
      chk("rst_drop", req_drop, 0);
      chk("rst_busy", busy, 0);
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      mon_en = 1'b1;

      // Read reply: latency and frame length
      push(1'b1, 24'h123456, 16'hBEEF, k);
      chk("busy_on_accept", busy, 1);
      n = 0;
      while (uart_tx !== 1'b0 && n < 50) begin
         @(negedge sys_clk);
         n++;
      end
      chk("launch_latency", cyc - k, 2);
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("read_busy_fall", cyc - k, 561);
      drain();

      // Write acknowledge
      push(1'b0, 24'h000010, 16'h1234, k);
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("write_busy_fall", cyc - k, 401);
      drain();

      // Six consecutive pushes from idle
      gap_q.delete();
      @(posedge sys_clk); #1;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_type  = i[0];
         req_addr  = 24'h300000 + 24'(i * 24'h010203);
         req_data  = 16'hC000 + 16'(i * 16'h0111);
         if (i < 5) expect_frame(req_type, req_addr, req_data);
         @(posedge sys_clk); #1;
         chk("b2b_ready", req_ready, exp_rdy[i]);
         chk("b2b_drop", req_drop, (i == 5));
      end
      req_valid = 1'b0;
      @(posedge sys_clk); #1;
      chk("drop_one_cycle", req_drop, 0);
      drain();
      chk("b2b_frames", gap_q.size(), 5);
      for (int i = 1; i < 5; i++)
         if (gap_q.size() > i) chk("b2b_gap", gap_q[i], 9);

      // Push arriving mid-frame
      gap_q.delete();
      push(1'b1, 24'hA5A5A5, 16'h00FF, k);
      repeat (200) @(negedge sys_clk);
      push(1'b0, 24'hFFFFFF, 16'h0000, k2);
      drain();
      chk("mid_frames", gap_q.size(), 2);
      if (gap_q.size() > 1) chk("mid_gap", gap_q[1], 9);

      // Reset during a low data bit with requests still queued
      push(1'b1, 24'h000000, 16'h0000, k);
      push(1'b0, 24'h111111, 16'h0000, k2);
      push(1'b1, 24'h222222, 16'h3333, k2);
      while (cyc < k + 12) @(negedge sys_clk);
      chk("tx_low_before_reset", uart_tx, 0);
      mon_en = 1'b0;
      exp_q.delete();
      flen_q.delete();
      #2 sys_rst_n = 1'b0;
      #1;
      chk("async_rst_tx", uart_tx, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ready", req_ready, 1);
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      saw_low = 1'b0;
      repeat (200) begin
         @(negedge sys_clk);
         if (uart_tx !== 1'b1) saw_low = 1'b1;
      end
      chk("no_tx_after_reset", saw_low, 0);
      chk("idle_after_reset", busy, 0);
      mon_en = 1'b1;

      // Recovery after reset
      push(1'b0, 24'hABCDEF, 16'h0000, k);
      drain();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
